// File: rtl/rect_param_loader.sv
// rect_param_loader: streams per-rect x/y/w/h/color words from memory
// into shadow registers and commits the whole set in one cycle.
module rect_param_loader #(
  parameter int unsigned RECT_COUNT  = 64,
  parameter int unsigned FIELD_COUNT = 5,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 13,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 13'h1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rect_x     [RECT_COUNT],
  output logic [DATA_WIDTH-1:0] rect_y     [RECT_COUNT],
  output logic [DATA_WIDTH-1:0] rect_w     [RECT_COUNT],
  output logic [DATA_WIDTH-1:0] rect_h     [RECT_COUNT],
  output logic [DATA_WIDTH-1:0] rect_color [RECT_COUNT]
);

  localparam int unsigned N  = RECT_COUNT * FIELD_COUNT;
  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned RW =
    (RECT_COUNT > 1) ? $clog2(RECT_COUNT) : 1;
  localparam int unsigned FW =
    (FIELD_COUNT > 1) ? $clog2(FIELD_COUNT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    COMMIT
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mem_rd_q, mem_rd_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  valid_dly_q, valid_dly_d;
  logic [RW-1:0]         rect_q, rect_d;
  logic [FW-1:0]         field_q, field_d;

  logic [DATA_WIDTH-1:0] sh_q [RECT_COUNT][FIELD_COUNT];
  logic [DATA_WIDTH-1:0] sh_d [RECT_COUNT][FIELD_COUNT];
  logic [DATA_WIDTH-1:0] cm_q [RECT_COUNT][FIELD_COUNT];
  logic [DATA_WIDTH-1:0] cm_d [RECT_COUNT][FIELD_COUNT];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    valid_dly_d = mem_rd_q;
    rect_d      = rect_q;
    field_d     = field_q;
    sh_d        = sh_q;
    cm_d        = cm_q;

    // Data returned this cycle belongs to the read issued last cycle.
    if (valid_dly_q) begin
      sh_d[rect_q][field_q] = mem_data;
      if (field_q == FW'(FIELD_COUNT - 1)) begin
        field_d = '0;
        rect_d  = rect_q + RW'(1);
      end else begin
        field_d = field_q + FW'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = READ;
          cnt_d      = '0;
          mem_rd_d   = 1'b1;
          mem_addr_d = BASE_ADDR;
          busy_d     = 1'b1;
          rect_d     = '0;
          field_d    = '0;
        end
      end
      READ: begin
        if (cnt_q == CW'(N - 1)) begin
          state_d = DRAIN;
        end else begin
          cnt_d      = cnt_q + CW'(1);
          mem_rd_d   = 1'b1;
          mem_addr_d = BASE_ADDR
                     + ADDR_WIDTH'(cnt_q + CW'(1));
        end
      end
      DRAIN: begin
        // Commit sees the final word through the capture bypass.
        state_d = COMMIT;
        done_d  = 1'b1;
        cm_d    = sh_d;
      end
      COMMIT: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_dly_q <= 1'b0;
      rect_q      <= '0;
      field_q     <= '0;
      for (int r = 0; r < RECT_COUNT; r++) begin
        for (int f = 0; f < FIELD_COUNT; f++) begin
          sh_q[r][f] <= '0;
          cm_q[r][f] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      valid_dly_q <= valid_dly_d;
      rect_q      <= rect_d;
      field_q     <= field_d;
      sh_q        <= sh_d;
      cm_q        <= cm_d;
    end
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

  always_comb begin
    for (int r = 0; r < RECT_COUNT; r++) begin
      rect_x[r]     = cm_q[r][0];
      rect_y[r]     = cm_q[r][1];
      rect_w[r]     = cm_q[r][2];
      rect_h[r]     = cm_q[r][3];
      rect_color[r] = cm_q[r][4];
    end
  end

endmodule

// File: tb/tb_rect_param_loader.sv
// tb_rect_param_loader: directed + random loads against a memory-image
// model of the committed rect arrays, two instances (normal, wrapping).
module tb_rect_param_loader;

  localparam int RC = 64;
  localparam int FC = 5;
  localparam int N  = RC * FC;
  localparam int DW = 16;
  localparam int AW = 13;
  localparam int MS = 1 << AW;
  localparam logic [AW-1:0] B1 = 13'h1000;
  localparam logic [AW-1:0] B2 = 13'h1FF0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start1 = 1'b0;
  logic start2 = 1'b0;
  logic rd1, rd2, busy1, busy2, done1, done2;
  logic [AW-1:0] a1, a2;
  logic [DW-1:0] d1, d2;
  logic [DW-1:0] x1 [RC], y1 [RC], w1 [RC], h1 [RC], c1 [RC];
  logic [DW-1:0] x2 [RC], y2 [RC], w2 [RC], h2 [RC], c2 [RC];

  logic [DW-1:0] mem [MS];
  logic [DW-1:0] ex  [2][RC][FC];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd1) d1 <= mem[a1];
    if (rd2) d2 <= mem[a2];
  end

  rect_param_loader #(.BASE_ADDR(B1)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start1),
    .mem_rd(rd1), .mem_addr(a1), .mem_data(d1),
    .busy(busy1), .done(done1),
    .rect_x(x1), .rect_y(y1), .rect_w(w1),
    .rect_h(h1), .rect_color(c1)
  );

  rect_param_loader #(.BASE_ADDR(B2)) u2 (
    .clk(clk), .reset_n(reset_n), .start(start2),
    .mem_rd(rd2), .mem_addr(a2), .mem_data(d2),
    .busy(busy2), .done(done2),
    .rect_x(x2), .rect_y(y2), .rect_w(w2),
    .rect_h(h2), .rect_color(c2)
  );

  task automatic check(input string tag,
                       input logic [31:0] o,
                       input logic [31:0] e);
    checks++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
  endtask

  function automatic logic [DW-1:0] obs(input int s, input int r,
                                        input int f);
    logic [DW-1:0] v;
    v = '0;
    case (f)
      0: v = s ? x2[r] : x1[r];
      1: v = s ? y2[r] : y1[r];
      2: v = s ? w2[r] : w1[r];
      3: v = s ? h2[r] : h1[r];
      default: v = s ? c2[r] : c1[r];
    endcase
    return v;
  endfunction

  function automatic logic rdv(input int s);
    return s ? rd2 : rd1;
  endfunction

  function automatic logic busyv(input int s);
    return s ? busy2 : busy1;
  endfunction

  function automatic logic donev(input int s);
    return s ? done2 : done1;
  endfunction

  function automatic int addrv(input int s);
    return s ? int'(a2) : int'(a1);
  endfunction

  function automatic int basev(input int s);
    return s ? int'(B2) : int'(B1);
  endfunction

  task automatic set_start(input int s, input logic v);
    if (s != 0) start2 = v;
    else start1 = v;
  endtask

  task automatic fill(input int s, input int mode);
    for (int i = 0; i < N; i++) begin
      int a;
      a = (basev(s) + i) % MS;
      if (mode == 0) mem[a] = DW'(i);
      else if (mode == 1) mem[a] = DW'(i + 'h100);
      else mem[a] = DW'($urandom);
    end
  endtask

  // Word k of the image is rect k/FC, field k%FC.
  task automatic model_commit(input int s);
    for (int r = 0; r < RC; r++)
      for (int f = 0; f < FC; f++)
        ex[s][r][f] = mem[(basev(s) + r * FC + f) % MS];
  endtask

  task automatic model_clear();
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < RC; r++)
        for (int f = 0; f < FC; f++)
          ex[s][r][f] = '0;
  endtask

  task automatic compare_all(input int s, input string tag);
    int bad;
    bad = 0;
    for (int r = 0; r < RC; r++)
      for (int f = 0; f < FC; f++)
        if (obs(s, r, f) !== ex[s][r][f]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic run_load(input int s, input int rp1, input int rp2,
                          input bit rp_commit, input int abort_at);
    int reads, done_cyc, bad_addr, extra;
    reads = 0;
    done_cyc = -1;
    bad_addr = 0;
    set_start(s, 1'b1);
    @(posedge clk); #1;
    set_start(s, 1'b0);
    for (int cyc = 1; cyc <= N + 20; cyc++) begin
      set_start(s, (cyc == rp1) || (cyc == rp2));
      if (cyc == 1) begin
        check("busy_first", busyv(s), 1);
        check("done_first", donev(s), 0);
      end
      if (rdv(s)) begin
        if (addrv(s) != (basev(s) + reads) % MS) bad_addr++;
        reads++;
      end
      if (cyc == N + 1) begin
        check("hold_x0", obs(s, 0, 0), ex[s][0][0]);
        check("hold_c63", obs(s, RC - 1, 4), ex[s][RC - 1][4]);
      end
      if (abort_at > 0 && reads == abort_at) begin
        reset_n = 1'b0;
        #1;
        model_clear();
        compare_all(s, "abort_zero");
        check("abort_busy", busyv(s), 0);
        check("abort_rd", rdv(s), 0);
        extra = 0;
        repeat (3) begin
          @(posedge clk); #1;
          if (donev(s) !== 1'b0) extra++;
        end
        check("abort_nodone", extra, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (donev(s)) begin
        done_cyc = cyc;
        if (rp_commit) set_start(s, 1'b1);
        model_commit(s);
        compare_all(s, "commit_all");
        break;
      end
      @(posedge clk); #1;
    end
    check("done_cycle", done_cyc, N + 2);
    check("read_count", reads, N);
    check("addr_seq", bad_addr, 0);
    @(posedge clk); #1;
    set_start(s, 1'b0);
    check("after_busy", busyv(s), 0);
    check("after_done", donev(s), 0);
    if (rp_commit) begin
      extra = 0;
      repeat (5) begin
        if (rdv(s) !== 1'b0 || donev(s) !== 1'b0) extra++;
        @(posedge clk); #1;
      end
      check("commit_start_ignored", extra, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < MS; i++) mem[i] = '0;
    model_clear();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compare_all(0, "reset_arr");
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_rd", rd1, 0);
    check("idle_busy", busy1, 0);
    check("idle_done", done1, 0);
    check("idle_addr", a1, 0);
    compare_all(0, "idle_arr");
    compare_all(1, "idle_arr2");

    fill(0, 0);
    run_load(0, 0, 0, 1'b0, 0);
    check("x0", x1[0], 0);
    check("color0", c1[0], 4);
    check("y7", y1[7], 36);
    check("h63", h1[63], 318);
    check("color63", c1[63], 319);

    fill(0, 1);
    run_load(0, 5, 100, 1'b0, 0);
    check("x0_second", x1[0], 'h100);

    fill(0, 2);
    run_load(0, 0, 0, 1'b1, 0);

    fill(0, 2);
    run_load(0, 0, 0, 1'b0, 150);

    fill(0, 2);
    run_load(0, 0, 0, 1'b0, 0);

    fill(1, 2);
    run_load(1, 0, 0, 1'b0, 0);
    check("wrap_x0", x2[0], mem[int'(B2)]);
    check("wrap_c63", c2[RC - 1], mem[(int'(B2) + N - 1) % MS]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
